// File: rtl/comparator_pkg.sv
// Shared types for the serial magnitude comparator: FSM state encoding,
// per-bit classification codes and a helper that folds the bit cell's
// lt/gt pair into one code.
package comparator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RES_EQ = 2'd0,
    RES_LT = 2'd1,
    RES_GT = 2'd2
  } bit_res_t;

  // Fold the cell's two flags into a single result code. If both flags are
  // somehow set, less-than wins so that the result stays one-hot.
  function automatic bit_res_t classify_bit(input logic lt, input logic gt);
    bit_res_t res;
    if (lt) begin
      res = RES_LT;
    end else if (gt) begin
      res = RES_GT;
    end else begin
      res = RES_EQ;
    end
    return res;
  endfunction

endpackage

// File: rtl/bit_compare_cell.sv
// Combinational classification of one bit pair. For the sign bit of a
// two's-complement operand the sense is inverted: a set sign bit means
// the operand is more negative.
module bit_compare_cell (
  input  logic a,
  input  logic b,
  input  logic is_sign,
  input  logic signed_mode,
  output logic lt,
  output logic gt
);

  logic invert_s;

  // Classify a against b, inverting the sense on the signed sign bit
  always_comb begin
    lt       = 1'b0;
    gt       = 1'b0;
    invert_s = is_sign & signed_mode;
    if (invert_s) begin
      lt = a & ~b;
      gt = ~a & b;
    end else begin
      lt = ~a & b;
      gt = a & ~b;
    end
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator. Operands are captured on start, then
// examined one bit pair per cycle from the MSB down; the first difference
// ends the comparison early. L/E/G hold from one DONE entry to the next.
module serial_magnitude_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             L,
  output logic             E,
  output logic             G
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             sm_r;
  logic [IDX_W-1:0] idx_r;
  logic             busy_r;
  logic             done_r;
  logic             l_r;
  logic             e_r;
  logic             g_r;

  logic             bit_a_s;
  logic             bit_b_s;
  logic             is_sign_s;
  logic             last_s;
  logic             lt_s;
  logic             gt_s;
  bit_res_t         res_s;
  logic             accept_s;
  logic             finish_s;

  // Select the bit pair under examination and flag sign/last positions
  always_comb begin
    bit_a_s   = a_r[idx_r];
    bit_b_s   = b_r[idx_r];
    is_sign_s = (idx_r == IDX_MSB);
    last_s    = (idx_r == IDX_ZERO);
  end

  bit_compare_cell u_cell (
    .a           (bit_a_s),
    .b           (bit_b_s),
    .is_sign     (is_sign_s),
    .signed_mode (sm_r),
    .lt          (lt_s),
    .gt          (gt_s)
  );

  // Reduce the cell flags to a single result code
  always_comb begin
    res_s = classify_bit(lt_s, gt_s);
  end

  // Next-state logic plus capture/finish strobes
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s  = ST_CMP;
          accept_s = 1'b1;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_CMP: begin
        if ((res_s != RES_EQ) || last_s) begin
          state_s  = ST_DONE;
          finish_s = 1'b1;
        end else begin
          state_s  = ST_CMP;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_s  = ST_CMP;
          accept_s = 1'b1;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register, registered status flags and held results
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      l_r     <= 1'b0;
      e_r     <= 1'b0;
      g_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == ST_CMP);
      done_r  <= (state_s == ST_DONE);
      if (finish_s) begin
        case (res_s)
          RES_LT: begin
            l_r <= 1'b1;
            e_r <= 1'b0;
            g_r <= 1'b0;
          end
          RES_GT: begin
            l_r <= 1'b0;
            e_r <= 1'b0;
            g_r <= 1'b1;
          end
          default: begin
            l_r <= 1'b0;
            e_r <= 1'b1;
            g_r <= 1'b0;
          end
        endcase
      end else begin
        l_r <= l_r;
        e_r <= e_r;
        g_r <= g_r;
      end
    end
  end

  // Operand capture and MSB-first bit index
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
      sm_r  <= 1'b0;
      idx_r <= IDX_ZERO;
    end else if (accept_s) begin
      a_r   <= A;
      b_r   <= B;
      sm_r  <= signed_mode;
      idx_r <= IDX_MSB;
    end else if ((state_r == ST_CMP) && !finish_s) begin
      idx_r <= idx_r - IDX_ONE;
    end else begin
      idx_r <= idx_r;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign L    = l_r;
  assign E    = e_r;
  assign G    = g_r;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for the serial magnitude comparator at WIDTH=8.
module tb_serial_magnitude_comparator;

  logic       clk;
  logic       rst;
  logic       start;
  logic       signed_mode;
  logic [7:0] A;
  logic [7:0] B;
  logic       busy;
  logic       done;
  logic       L;
  logic       E;
  logic       G;

  int n_cmp;
  int n_bad;
  int busy_cyc;

  serial_magnitude_comparator #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .L           (L),
    .E           (E),
    .G           (G)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive operands with start high across one edge (t0), then drop start.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic sm);
    A           = a;
    B           = b;
    signed_mode = sm;
    start       = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
  endtask

  // Called just after t0. Counts edges until done, checks latency, result,
  // that L/E/G did not move during CMP, and that busy is low in DONE.
  // glitch_at >= 0 pulses start with A=0xFF before that edge count.
  task automatic wait_done(input string tag, input int exp_lat, input logic [2:0] exp_leg,
                           input int glitch_at, output int n_busy);
    int       edges;
    bit       seen;
    bit       moved;
    logic [2:0] leg0;
    edges  = 0;
    seen   = 1'b0;
    moved  = 1'b0;
    leg0   = {L, E, G};
    n_busy = busy ? 1 : 0;
    while (!seen && edges < 20) begin
      if (edges == glitch_at) begin
        start = 1'b1;
        A     = 8'hFF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) n_busy++;
        if ({L, E, G} !== leg0) moved = 1'b1;
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(edges), 32'(exp_lat));
    chk({tag, "_LEG"}, 32'({L, E, G}), 32'(exp_leg));
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    chk({tag, "_hold_in_cmp"}, 32'(moved), 32'd0);
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    rst         = 1'b1;
    start       = 1'b1;
    signed_mode = 1'b0;
    A           = 8'h00;
    B           = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({busy, done, L, E, G}), 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_reset", 32'({busy, done}), 32'd0);

    // Unsigned early exit on bit 7: 0xA5 > 0x25
    launch(8'hA5, 8'h25, 1'b0);
    chk("a5_busy_t0", 32'(busy), 32'd1);
    wait_done("a5_gt", 1, 3'b001, -1, busy_cyc);
    @(posedge clk); #1;
    chk("a5_done_one_pulse", 32'(done), 32'd0);
    chk("a5_leg_held", 32'({L, E, G}), 32'b001);

    // Equal operands run the full width
    launch(8'h3C, 8'h3C, 1'b0);
    wait_done("3c_eq", 8, 3'b010, -1, busy_cyc);
    chk("3c_busy_cycles", 32'(busy_cyc), 32'd8);

    // Same operands, signed vs unsigned
    launch(8'h80, 8'h7F, 1'b1);
    wait_done("80_signed", 1, 3'b100, -1, busy_cyc);
    launch(8'h80, 8'h7F, 1'b0);
    wait_done("80_unsigned", 1, 3'b001, -1, busy_cyc);

    // LSB-only difference with an ignored start pulse in CMP
    launch(8'h12, 8'h13, 1'b0);
    wait_done("12_lt", 8, 3'b100, 2, busy_cyc);
    @(posedge clk); #1;
    chk("12_no_queued_start", 32'({busy, done}), 32'd0);

    // Reset during the third CMP cycle aborts without a done pulse
    launch(8'h01, 8'h02, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_outputs", 32'({busy, done, L, E, G}), 32'd0);
    @(posedge clk); #1;
    chk("abort_no_done", 32'(done), 32'd0);

    // Back-to-back: second start accepted in the DONE cycle
    launch(8'h40, 8'h40, 1'b0);
    wait_done("40_eq", 8, 3'b010, -1, busy_cyc);
    A           = 8'hC0;
    B           = 8'h40;
    signed_mode = 1'b1;
    start       = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
    chk("b2b_no_idle_gap", 32'(busy), 32'd1);
    wait_done("c0_signed_lt", 1, 3'b100, -1, busy_cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
